// File: rtl/game_pkg.sv
// Shared types and constants for the game flow controller.
//   game_state_t : screen/state codes driven onto screen_sel
//   BDR..CLK     : tile codes used by the level renderer
//   COIN_MAX     : coin tally saturation value
package game_pkg;

    typedef enum logic [2:0] {
        START       = 3'd0,
        PLAY        = 3'd1,
        DEATH       = 3'd2,
        LEVEL_CLEAR = 3'd3,
        WIN         = 3'd4,
        GAME_OVER   = 3'd5,
        PAUSE       = 3'd6
    } game_state_t;

    localparam logic [2:0] BDR = 3'd0;
    localparam logic [2:0] SKY = 3'd1;
    localparam logic [2:0] BLK = 3'd2;
    localparam logic [2:0] GND = 3'd3;
    localparam logic [2:0] TKN = 3'd4;
    localparam logic [2:0] CLK = 3'd5;

    localparam logic [6:0] COIN_MAX = 7'd99;

endpackage

// File: rtl/game_flow_controller_ticker.sv
// second_ticker: one-second prescaler.
//   vga_clock     in  clock
//   reset         in  synchronous active-high reset
//   i_run         in  count enable
//   i_clear       in  force count to zero (wins over i_run)
//   o_sec_tick_c  out combinational one-cycle pulse on the last count of a second
module second_ticker #(
    parameter int unsigned CLK_HZ = 25_000_000
) (
    input  logic vga_clock,
    input  logic reset,
    input  logic i_run,
    input  logic i_clear,
    output logic o_sec_tick_c
);

    localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(CLK_HZ - 1));

    // Tick is not gated by i_clear: the clear is itself derived from the tick
    assign o_sec_tick_c = i_run && w_wrap;

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_flow_controller.sv
// game_flow_controller: top-level game sequencer (lives, level timer, coins,
// death / level-clear / win / game-over screens).
// Optional macro PAUSE_EN adds a PAUSE state toggled by the start button in PLAY.
//   vga_clock        in  sole clock
//   reset            in  synchronous active-high reset
//   i_start_button   in  raw push button, active-low
//   i_level_complete in  pulse: flag reached
//   i_player_died    in  pulse: enemy or pit hit
//   i_coin_touch     in  per-coin pulses
//   o_screen_sel     out current state code
//   o_level_idx      out current level (0-based)
//   o_level_enable   out high only in PLAY
//   o_level_reset    out pulse on PLAY entry (not on resume from PAUSE)
//   o_seconds_left   out remaining level time
//   o_lives          out remaining lives
//   o_coins          out coin tally, saturating
//   o_leds           out {start pressed, 000, level_idx, lives}
module game_flow_controller
    import game_pkg::*;
#(
    parameter int unsigned NUM_LEVELS   = 2,
    parameter int unsigned START_LIVES  = 3,
    parameter int unsigned LEVEL_TIME_S = 300,
    parameter int unsigned CLK_HZ       = 25_000_000,
    parameter int unsigned HOLD_S       = 3,
    parameter int unsigned NUM_COINS    = 3
) (
    input  logic                 vga_clock,
    input  logic                 reset,
    input  logic                 i_start_button,
    input  logic                 i_level_complete,
    input  logic                 i_player_died,
    input  logic [NUM_COINS-1:0] i_coin_touch,
    output logic [2:0]           o_screen_sel,
    output logic [2:0]           o_level_idx,
    output logic                 o_level_enable,
    output logic                 o_level_reset,
    output logic [8:0]           o_seconds_left,
    output logic [2:0]           o_lives,
    output logic [6:0]           o_coins,
    output logic [9:0]           o_leds
);

    localparam int unsigned HOLD_W = (HOLD_S > 1) ? $clog2(HOLD_S) : 1;

    game_state_t       r_state;
    game_state_t       w_next;
    logic [1:0]        r_sync;
    logic              r_btn_prev;
    logic [HOLD_W-1:0] r_hold;
    logic [2:0]        r_level_idx;
    logic [2:0]        r_lives;
    logic [6:0]        r_coins;
    logic [8:0]        r_seconds_left;
    logic              r_level_enable;
    logic              r_level_reset;

    logic              w_press;
    logic              w_sec_tick;
    logic              w_run;
    logic              w_clear;
    logic              w_pause_swap;
    logic              w_enter_play;
    logic              w_timeout;
    logic              w_hold_done;
    logic [7:0]        w_pop;
    logic [8:0]        w_coin_sum;
    logic [6:0]        w_coins_next;

    // Button is active-low: a press is a falling edge of the synchronised level
    assign w_press = r_btn_prev && !r_sync[1];

    assign w_run        = (r_state == PLAY) || (r_state == DEATH) || (r_state == LEVEL_CLEAR);
    assign w_pause_swap = (r_state == PAUSE) || (w_next == PAUSE);
    // Prescaler restarts on every state change except entering/leaving PAUSE
    assign w_clear      = (w_next != r_state) && !w_pause_swap;
    assign w_enter_play = (w_next == PLAY) && (r_state != PLAY) && (r_state != PAUSE);
    assign w_timeout    = w_sec_tick && (r_seconds_left == 9'd1);
    assign w_hold_done  = w_sec_tick && (r_hold == HOLD_W'(HOLD_S - 1));

    second_ticker #(
        .CLK_HZ(CLK_HZ)
    ) u_ticker (
        .vga_clock   (vga_clock),
        .reset       (reset),
        .i_run       (w_run),
        .i_clear     (w_clear),
        .o_sec_tick_c(w_sec_tick)
    );

    // Coin popcount and saturating add
    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < NUM_COINS; i++) begin
            w_pop = w_pop + 8'(i_coin_touch[i]);
        end
        w_coin_sum   = 9'(r_coins) + 9'(w_pop);
        w_coins_next = (w_coin_sum > 9'(COIN_MAX)) ? COIN_MAX : w_coin_sum[6:0];
    end

    // State register
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            r_state <= START;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            START: begin
                if (w_press) w_next = PLAY;
            end
            PLAY: begin
                if (i_level_complete) begin
                    w_next = LEVEL_CLEAR;
                end else if (i_player_died || w_timeout) begin
                    w_next = DEATH;
                end
`ifdef PAUSE_EN
                else if (w_press) begin
                    w_next = PAUSE;
                end
`endif
            end
            DEATH: begin
                if (w_hold_done) w_next = (r_lives == 3'd0) ? GAME_OVER : PLAY;
            end
            LEVEL_CLEAR: begin
                if (w_hold_done) w_next = (r_level_idx == 3'(NUM_LEVELS - 1)) ? WIN : PLAY;
            end
            WIN, GAME_OVER: begin
                if (w_press) w_next = START;
            end
`ifdef PAUSE_EN
            PAUSE: begin
                if (w_press) w_next = PLAY;
            end
`endif
            default: w_next = START;
        endcase
    end

    // Game datapath and registered outputs
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            r_sync         <= 2'b11;
            r_btn_prev     <= 1'b1;
            r_hold         <= '0;
            r_level_idx    <= 3'd0;
            r_lives        <= 3'(START_LIVES);
            r_coins        <= 7'd0;
            r_seconds_left <= 9'(LEVEL_TIME_S);
            r_level_enable <= 1'b0;
            r_level_reset  <= 1'b0;
        end else begin
            r_sync         <= {r_sync[0], i_start_button};
            r_btn_prev     <= r_sync[1];
            r_level_enable <= (w_next == PLAY);
            r_level_reset  <= w_enter_play;

            if (w_clear) begin
                r_hold <= '0;
            end else if (w_sec_tick && (r_state == DEATH || r_state == LEVEL_CLEAR)) begin
                r_hold <= r_hold + HOLD_W'(1);
            end

            if (w_enter_play) begin
                r_seconds_left <= 9'(LEVEL_TIME_S);
            end else if (r_state == PLAY && w_next == DEATH) begin
                r_seconds_left <= 9'd0;
            end else if (r_state == PLAY && w_sec_tick) begin
                r_seconds_left <= r_seconds_left - 9'd1;
            end

            if (r_state == START && w_next == PLAY) begin
                r_lives <= 3'(START_LIVES);
            end else if (w_next == DEATH && r_state != DEATH) begin
                r_lives <= r_lives - 3'd1;
            end

            if (r_state == START && w_next == PLAY) begin
                r_level_idx <= 3'd0;
            end else if (r_state == LEVEL_CLEAR && w_next == PLAY) begin
                r_level_idx <= r_level_idx + 3'd1;
            end

            if (r_state == START && w_next == PLAY) begin
                r_coins <= 7'd0;
            end else if (r_state == PLAY) begin
                r_coins <= w_coins_next;
            end
        end
    end

    assign o_screen_sel   = r_state;
    assign o_level_idx    = r_level_idx;
    assign o_level_enable = r_level_enable;
    assign o_level_reset  = r_level_reset;
    assign o_seconds_left = r_seconds_left;
    assign o_lives        = r_lives;
    assign o_coins        = r_coins;
    assign o_leds         = {!r_sync[1], 3'b000, r_level_idx, r_lives};

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller (CLK_HZ = 10, LEVEL_TIME_S = 3).
module tb_game_flow_controller;
    import game_pkg::*;

    logic       vga_clock = 1'b0;
    logic       reset;
    logic       start_button;
    logic       level_complete;
    logic       player_died;
    logic [2:0] coin_touch;
    logic [2:0] screen_sel;
    logic [2:0] level_idx;
    logic       level_enable;
    logic       level_reset;
    logic [8:0] seconds_left;
    logic [2:0] lives;
    logic [6:0] coins;
    logic [9:0] leds;

    always #5 vga_clock = ~vga_clock;

    game_flow_controller #(
        .NUM_LEVELS  (2),
        .START_LIVES (3),
        .LEVEL_TIME_S(3),
        .CLK_HZ      (10),
        .HOLD_S      (3),
        .NUM_COINS   (3)
    ) dut (
        .vga_clock       (vga_clock),
        .reset           (reset),
        .i_start_button  (start_button),
        .i_level_complete(level_complete),
        .i_player_died   (player_died),
        .i_coin_touch    (coin_touch),
        .o_screen_sel    (screen_sel),
        .o_level_idx     (level_idx),
        .o_level_enable  (level_enable),
        .o_level_reset   (level_reset),
        .o_seconds_left  (seconds_left),
        .o_lives         (lives),
        .o_coins         (coins),
        .o_leds          (leds)
    );

    typedef struct {
        int st;
        int lvl;
        int lv;
        int sec;
        int cn;
        int en;
        int lr;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t exp;
    } vec_t;

    obs_t exp_q[$];
    vec_t tv[10];
    int   n_chk = 0;
    int   n_err = 0;
    int   lr_cnt, tr_cnt, prev_st, lv_at, sec_at, c, bad, sec0;

    function automatic obs_t mk(input int st, input int lvl, input int lv, input int sec,
                                input int cn, input int en, input int lr);
        obs_t o;
        o.st = st; o.lvl = lvl; o.lv = lv; o.sec = sec; o.cn = cn; o.en = en; o.lr = lr;
        return o;
    endfunction

    task automatic chk_int(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clock);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_push(input obs_t o);
        exp_q.push_back(o);
    endtask

    task automatic expect_pop(input string nm);
        obs_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: scoreboard empty", nm);
            return;
        end
        e = exp_q.pop_front();
        chk_int({nm, ".screen"}, int'(screen_sel), e.st);
        chk_int({nm, ".level"},  int'(level_idx), e.lvl);
        chk_int({nm, ".lives"},  int'(lives), e.lv);
        chk_int({nm, ".secs"},   int'(seconds_left), e.sec);
        chk_int({nm, ".coins"},  int'(coins), e.cn);
        chk_int({nm, ".enable"}, int'(level_enable), e.en);
        chk_int({nm, ".lreset"}, int'(level_reset), e.lr);
        chk_int({nm, ".leds"},   int'(leds[8:0]), (e.lvl << 3) | e.lv);
    endtask

    task automatic wait_state(input int st, input int bound, input string nm);
        int k;
        k = 0;
        while (int'(screen_sel) != st && k < bound) begin
            tick();
            k++;
        end
        chk_int({nm, ".reached"}, int'(screen_sel), st);
    endtask

    task automatic press_until(input int st, input string nm);
        start_button = 1'b0;
        wait_state(st, 10, nm);
        start_button = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        tv[0] = '{0,  mk(PLAY, 0, 3, 3, 0, 1, 1)};
        tv[1] = '{1,  mk(PLAY, 0, 3, 3, 0, 1, 0)};
        tv[2] = '{9,  mk(PLAY, 0, 3, 3, 0, 1, 0)};
        tv[3] = '{10, mk(PLAY, 0, 3, 2, 0, 1, 0)};
        tv[4] = '{20, mk(PLAY, 0, 3, 1, 0, 1, 0)};
        tv[5] = '{29, mk(PLAY, 0, 3, 1, 0, 1, 0)};
        tv[6] = '{30, mk(DEATH, 0, 2, 0, 0, 0, 0)};
        tv[7] = '{59, mk(DEATH, 0, 2, 0, 0, 0, 0)};
        tv[8] = '{60, mk(PLAY, 0, 2, 3, 0, 1, 1)};
        tv[9] = '{61, mk(PLAY, 0, 2, 3, 0, 1, 0)};

        reset = 1'b1; start_button = 1'b1; level_complete = 1'b0;
        player_died = 1'b0; coin_touch = 3'b000;
        tick_n(3);
        expect_push(mk(START, 0, 3, 3, 0, 0, 0));
        expect_pop("reset");
        reset = 1'b0;
        tick();
        expect_push(mk(START, 0, 3, 3, 0, 0, 0));
        expect_pop("idle");

        // Held button: one START->PLAY transition and one level_reset pulse
        lr_cnt = 0; tr_cnt = 0; lv_at = -1; sec_at = -1;
        prev_st = int'(screen_sel);
        start_button = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (level_reset) begin
                lr_cnt++;
                lv_at  = int'(lives);
                sec_at = int'(seconds_left);
            end
            if (prev_st == int'(START) && int'(screen_sel) == int'(PLAY)) tr_cnt++;
            prev_st = int'(screen_sel);
        end
        start_button = 1'b1;
        chk_int("hold.lreset_pulses", lr_cnt, 1);
        chk_int("hold.transitions", tr_cnt, 1);
        chk_int("hold.lives", lv_at, 3);
        chk_int("hold.secs", sec_at, 3);

        reset = 1'b1;
        tick_n(2);
        reset = 1'b0;
        tick();

        // Level timeout, death and respawn timing
        press_until(PLAY, "enter");
        c = 0;
        for (int r = 0; r < 10; r++) begin
            while (c < tv[r].cyc) begin
                tick();
                c++;
            end
            expect_push(tv[r].exp);
            expect_pop($sformatf("t%0d", tv[r].cyc));
        end

        // Remaining lives lost -> GAME_OVER, then restart
        player_died = 1'b1;
        expect_push(mk(DEATH, 0, 1, 0, 0, 0, 0));
        tick();
        player_died = 1'b0;
        expect_pop("die1");
        wait_state(PLAY, 40, "respawn1");
        player_died = 1'b1;
        expect_push(mk(DEATH, 0, 0, 0, 0, 0, 0));
        tick();
        player_died = 1'b0;
        expect_pop("die2");
        wait_state(GAME_OVER, 40, "gameover");
        expect_push(mk(GAME_OVER, 0, 0, 0, 0, 0, 0));
        expect_pop("gameover");
        tick_n(4);
        press_until(START, "to_start");
        tick_n(4);
        press_until(PLAY, "restart");
        expect_push(mk(PLAY, 0, 3, 3, 0, 1, 1));
        expect_pop("restart");

        // Coin saturation, with pulses held through a DEATH hold
        coin_touch = 3'b111;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (k == 30) begin
                chk_int("coins.death_entry_state", int'(screen_sel), int'(DEATH));
                chk_int("coins.death_entry", int'(coins), 90);
            end
            if (k == 59) chk_int("coins.death_end", int'(coins), 90);
        end
        coin_touch = 3'b000;
        expect_push(mk(PLAY, 0, 2, 2, 99, 1, 0));
        expect_pop("coins.sat");

        // level_complete beats player_died; two clears -> WIN
        level_complete = 1'b1;
        player_died    = 1'b1;
        expect_push(mk(LEVEL_CLEAR, 0, 2, 2, 99, 0, 0));
        tick();
        level_complete = 1'b0;
        player_died    = 1'b0;
        expect_pop("lc_prio");
        wait_state(PLAY, 40, "next_level");
        expect_push(mk(PLAY, 1, 2, 3, 99, 1, 1));
        expect_pop("level1");
        level_complete = 1'b1;
        expect_push(mk(LEVEL_CLEAR, 1, 2, 3, 99, 0, 0));
        tick();
        level_complete = 1'b0;
        expect_pop("lc2");
        wait_state(WIN, 40, "win");
        expect_push(mk(WIN, 1, 2, 3, 99, 0, 0));
        expect_pop("win");

        // Reset in the middle of a LEVEL_CLEAR hold
        tick_n(4);
        press_until(START, "win_start");
        tick_n(4);
        press_until(PLAY, "p2");
        level_complete = 1'b1;
        tick();
        level_complete = 1'b0;
        chk_int("p2.clear", int'(screen_sel), int'(LEVEL_CLEAR));
        tick_n(5);
        reset = 1'b1;
        expect_push(mk(START, 0, 3, 3, 0, 0, 0));
        tick();
        expect_pop("mid_reset");
        reset = 1'b0;
        expect_push(mk(START, 0, 3, 3, 0, 0, 0));
        tick();
        expect_pop("post_reset");

        // Prescaler restarts from zero on a fresh PLAY entry
        tick_n(4);
        press_until(PLAY, "p3");
        tick_n(9);
        chk_int("p3.secs_c9", int'(seconds_left), 3);
        tick();
        chk_int("p3.secs_c10", int'(seconds_left), 2);

`ifdef PAUSE_EN
        tick_n(4);
        press_until(PAUSE, "pause");
        sec0 = int'(seconds_left);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (int'(screen_sel) != int'(PAUSE) || int'(seconds_left) != sec0 || level_enable)
                bad++;
        end
        chk_int("pause.frozen_cycles_bad", bad, 0);
        tick_n(4);
        press_until(PLAY, "resume");
        chk_int("resume.lreset", int'(level_reset), 0);
        chk_int("resume.secs", int'(seconds_left), sec0);
`else
        // Without pause support a press in PLAY changes nothing
        tick_n(4);
        start_button = 1'b0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (int'(screen_sel) != int'(PLAY)) bad++;
        end
        start_button = 1'b1;
        chk_int("nopause.stay_play_bad", bad, 0);
`endif

        chk_int("scoreboard.leftover", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
